// File: rtl/jk_prime_seq.sv
// Prime-number sequencer built from a WIDTH-bit bank of JK flip-flops (up/down, load with prime snap, wrap pulse).
// Latency: one clk from a sampled en/load to the new Q; QN, wrap and idx are registered alongside Q.
// Backpressure: none; en=0 holds the state. Build with PRIME_IDX_EN to add the prime-index output idx.
module jk_prime_seq #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             wrap
`ifdef PRIME_IDX_EN
    ,
    output logic [IDX_W-1:0] idx
`endif
);

    localparam int NV   = 1 << WIDTH;
    localparam int PMIN = 2;

    typedef logic [NV-1:0][WIDTH-1:0] vtab_t;
    typedef logic [NV-1:0]            btab_t;

    // Values stay below 256, so divisors up to 15 are enough.
    function automatic logic is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < 16; d++)
            if (d < n && (n % d) == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_ge(int v);
        int r = -1;
        for (int n = NV - 1; n >= 0; n--)
            if (n >= v && is_prime(n)) r = n;
        return r;
    endfunction

    function automatic int last_le(int v);
        int r = -1;
        for (int n = 0; n < NV; n++)
            if (n <= v && is_prime(n)) r = n;
        return r;
    endfunction

    localparam int PMAX = last_le(NV - 1);

    // mode 0: ascending step, 1: descending step, 2: load snap, 3: prime index
    function automatic int step_val(int mode, int v);
        int r;
        case (mode)
            0: begin r = first_ge(v + 1); if (r < 0) r = PMIN; end
            1: begin r = last_le(v - 1);  if (r < 0) r = PMAX; end
            2: begin r = first_ge(v);     if (r < 0) r = PMIN; end
            default: begin
                r = 0;
                for (int n = 0; n < NV; n++)
                    if (n < v && is_prime(n)) r++;
            end
        endcase
        return r;
    endfunction

    function automatic vtab_t build_val(int mode);
        vtab_t t;
        for (int v = 0; v < NV; v++) t[v] = WIDTH'(step_val(mode, v));
        return t;
    endfunction

    function automatic btab_t build_wrap(logic up);
        btab_t t;
        for (int v = 0; v < NV; v++)
            t[v] = up ? (first_ge(v + 1) < 0) : (last_le(v - 1) < 0);
        return t;
    endfunction

    localparam vtab_t UP_T   = build_val(0);
    localparam vtab_t DN_T   = build_val(1);
    localparam vtab_t SNAP_T = build_val(2);
    localparam btab_t UP_W   = build_wrap(1'b1);
    localparam btab_t DN_W   = build_wrap(1'b0);
    localparam logic [WIDTH-1:0] PMIN_V = WIDTH'(PMIN);

    function automatic logic jk(logic q, logic j, logic k);
        case ({j, k})
            2'b10:   return 1'b1;
            2'b01:   return 1'b0;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    logic [WIDTH-1:0] nxt;
    logic             nxt_wrap;

    always_comb begin
        nxt      = Q;
        nxt_wrap = 1'b0;
        if (load) begin
            nxt = SNAP_T[load_val];
        end else if (en) begin
            if (dir) begin
                nxt      = UP_T[Q];
                nxt_wrap = UP_W[Q];
            end else begin
                nxt      = DN_T[Q];
                nxt_wrap = DN_W[Q];
            end
        end
    end

`ifdef PRIME_IDX_EN
    localparam vtab_t IDX_T = build_val(3);
`endif

    // Q takes J=nxt/K=~nxt; QN is its own JK bank with the swapped excitation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= PMIN_V;
            QN   <= ~PMIN_V;
            wrap <= 1'b0;
`ifdef PRIME_IDX_EN
            idx  <= '0;
`endif
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                Q[i]  <= jk(Q[i], nxt[i], ~nxt[i]);
                QN[i] <= jk(QN[i], ~nxt[i], nxt[i]);
            end
            wrap <= nxt_wrap;
`ifdef PRIME_IDX_EN
            idx  <= IDX_W'(IDX_T[nxt]);
`endif
        end
    end

endmodule

// File: tb/tb_jk_prime_seq.sv
// Self-checking bench for jk_prime_seq at WIDTH=4: vector table, reset corner cases, randomized run vs a prime-list model.
module tb_jk_prime_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] Q, QN;
    logic       wrap;
`ifdef PRIME_IDX_EN
    logic [3:0] idx;
`endif

    int checks = 0;
    int errors = 0;

    jk_prime_seq #(.WIDTH(4), .IDX_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
        .QN       (QN),
        .wrap     (wrap)
`ifdef PRIME_IDX_EN
        ,
        .idx      (idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dir;
        logic       load;
        logic [3:0] lv;
        int         q;
        int         w;
        int         ix;
    } vec_t;

    vec_t vecs[$];
    int   primes[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int q, input int w, input int ix);
        chk({tag, " Q"}, int'(Q), q);
        chk({tag, " QN"}, int'(QN), (~q) & 15);
        chk({tag, " wrap"}, int'(wrap), w);
`ifdef PRIME_IDX_EN
        chk({tag, " idx"}, int'(idx), ix);
`else
        if (ix < 0) $display("note: negative index %0d", ix);
`endif
    endtask

    task automatic add(input logic e, input logic d, input logic l, input logic [3:0] lv,
                       input int q, input int w, input int ix);
        vec_t v;
        v.en = e; v.dir = d; v.load = l; v.lv = lv; v.q = q; v.w = w; v.ix = ix;
        vecs.push_back(v);
    endtask

    function automatic bit prime_p(int n);
        if (n < 2) return 0;
        for (int d = 2; d < n; d++) if (n % d == 0) return 0;
        return 1;
    endfunction

    // Reference: walk the ascending prime list directly.
    function automatic void model(input int q, input bit e, input bit d, input bit l, input int lv,
                                  output int nq, output int w);
        nq = q; w = 0;
        if (l) begin
            nq = primes[0];
            for (int i = primes.size() - 1; i >= 0; i--) if (primes[i] >= lv) nq = primes[i];
        end else if (e && d) begin
            nq = -1;
            for (int i = primes.size() - 1; i >= 0; i--) if (primes[i] > q) nq = primes[i];
            if (nq < 0) begin nq = primes[0]; w = 1; end
        end else if (e) begin
            nq = -1;
            for (int i = 0; i < primes.size(); i++) if (primes[i] < q) nq = primes[i];
            if (nq < 0) begin nq = primes[primes.size() - 1]; w = 1; end
        end
    endfunction

    function automatic int pos_of(int q);
        for (int i = 0; i < primes.size(); i++) if (primes[i] == q) return i;
        return -1;
    endfunction

    initial begin
        int mq, nq, w;
        bit e, d, l;
        int lv;

        for (int n = 0; n < 16; n++) if (prime_p(n)) primes.push_back(n);

        // en=0 holds at 2
        for (int i = 0; i < 3; i++) add(0, 1, 0, 4'd0, 2, 0, 0);
        // ascending with wrap 13 -> 2
        add(1, 1, 0, 4'd0, 3, 0, 1);
        add(1, 1, 0, 4'd0, 5, 0, 2);
        add(1, 1, 0, 4'd0, 7, 0, 3);
        add(1, 1, 0, 4'd0, 11, 0, 4);
        add(1, 1, 0, 4'd0, 13, 0, 5);
        add(1, 1, 0, 4'd0, 2, 1, 0);
        add(1, 1, 0, 4'd0, 3, 0, 1);
        // descending with wrap 2 -> 13
        add(1, 0, 0, 4'd0, 2, 0, 0);
        add(1, 0, 0, 4'd0, 13, 1, 5);
        add(1, 0, 0, 4'd0, 11, 0, 4);
        // loads win over en; snapping and overflow
        add(1, 1, 1, 4'd8, 11, 0, 4);
        add(1, 1, 1, 4'd14, 2, 0, 0);
        add(1, 1, 1, 4'd0, 2, 0, 0);
        add(1, 0, 1, 4'd1, 2, 0, 0);
        add(1, 1, 1, 4'd13, 13, 0, 5);
        add(0, 0, 1, 4'd12, 13, 0, 5);
        add(1, 1, 1, 4'd15, 2, 0, 0);
        // en toggling with dir flip from 5
        add(0, 1, 1, 4'd5, 5, 0, 2);
        add(1, 1, 0, 4'd0, 7, 0, 3);
        add(0, 1, 0, 4'd0, 7, 0, 3);
        add(1, 0, 0, 4'd0, 5, 0, 2);
        add(0, 0, 1, 4'd8, 11, 0, 4);

        // Asynchronous reset with no clock edge needed
        #1 reset = 1'b0;
        #1 chk_outputs("async reset", 2, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 chk_outputs("reset held", 2, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; dir = vecs[i].dir; load = vecs[i].load; load_val = vecs[i].lv;
            @(posedge clk);
            #1 chk_outputs($sformatf("vec%0d", i), vecs[i].q, vecs[i].w, vecs[i].ix);
        end

        // Reset between edges while Q=11
        load = 1'b0; en = 1'b1; dir = 1'b1;
        #3 reset = 1'b0;
        #1 chk_outputs("midcycle reset", 2, 0, 0);
        @(posedge clk);
        #1 chk_outputs("reset over en", 2, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_outputs("first after release", 3, 0, 1);

        mq = 3;
        for (int c = 0; c < 300; c++) begin
            e  = ($urandom % 4) != 0;
            d  = $urandom % 2;
            l  = ($urandom % 8) == 0;
            lv = $urandom % 16;
            en = e; dir = d; load = l; load_val = 4'(lv);
            model(mq, e, d, l, lv, nq, w);
            mq = nq;
            @(posedge clk);
            #1 chk_outputs($sformatf("rand%0d", c), mq, w, pos_of(mq));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
